// File: rtl/down_timer_pkg.sv
// Shared encodings for the timing-chain blocks: FSM state codes and run-mode constants.
package down_timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  function automatic logic is_run(input state_e s);
    return s == S_RUN;
  endfunction

endpackage

// File: rtl/down_count_core.sv
// WIDTH-bit down counter: synchronous load has priority over decrement, which saturates at zero.
module down_count_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec_en,
  output logic [WIDTH-1:0] q,
  output logic             zero_c
);

  assign zero_c = (q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_val;
    end else if (dec_en && !zero_c) begin
      q <= q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/down_timer.sv
// Programmable down timer: one-shot or auto-reload periodic, one-cycle tc pulse at terminal count.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  state_e           state;
  logic [WIDTH-1:0] reload;
  logic             mode;
  logic             zero_c;
  logic             tick_c;
  logic             load_en_c;
  logic             dec_en_c;
  logic [WIDTH-1:0] load_val_c;

  // An enabled tick only counts when no command overrides it this cycle.
  assign tick_c     = is_run(state) && en && !start && !stop;
  assign load_en_c  = !stop && (start || (tick_c && zero_c && (mode == MODE_PERIODIC)));
  assign dec_en_c   = tick_c && !zero_c;
  assign load_val_c = start ? load : reload;

  down_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en_c),
    .load_val (load_val_c),
    .dec_en   (dec_en_c),
    .q        (Q),
    .zero_c   (zero_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      reload <= '0;
      mode   <= MODE_ONESHOT;
      tc     <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
      end else if (start) begin
        reload <= load;
        mode   <= periodic;
        // A zero load terminates at once so periodic mode cannot pulse tc every cycle.
        if (load == '0) begin
          state <= S_DONE;
          tc    <= 1'b1;
        end else begin
          state <= S_RUN;
        end
      end else if (tick_c && zero_c) begin
        tc <= 1'b1;
        if (mode == MODE_ONESHOT) begin
          state <= S_DONE;
        end
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: tick-count model compared every cycle plus directed literal checks.
module tb_down_timer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         en = 1'b0;
  logic         periodic = 1'b0;
  logic [W-1:0] load = '0;

  logic [W-1:0] q;
  logic         busy, done, tc;
  logic [3:0]   q4;
  logic         busy4, done4, tc4;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en),
    .periodic(periodic), .load(load), .Q(q), .busy(busy), .done(done), .tc(tc)
  );

  down_timer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en),
    .periodic(periodic), .load(load[3:0]), .Q(q4), .busy(busy4), .done(done4), .tc(tc4)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 run, 2 done. While running, Q follows from the enabled-tick count n since start.
  int phase = 0;
  int q_hold = 0;
  int lval = 0;
  int n = 0;
  bit per_m = 0;
  bit tc_exp = 0;
  bit chk_en = 0;

  function automatic int model_q();
    if (phase != 1) return q_hold;
    if (per_m) return lval - (n % (lval + 1));
    return lval - ((n < lval) ? n : lval);
  endfunction

  always @(posedge clk) begin
    tc_exp = 0;
    if (reset) begin
      phase = 0; q_hold = 0; lval = 0; n = 0; per_m = 0;
      chk_en = 1;
    end else if (stop) begin
      q_hold = model_q();
      phase = 0;
    end else if (start) begin
      lval = int'(load); per_m = periodic; n = 0;
      if (load == '0) begin
        phase = 2; q_hold = 0; tc_exp = 1;
      end else begin
        phase = 1;
      end
    end else if (phase == 1 && en) begin
      n++;
      if (n % (lval + 1) == 0) begin
        tc_exp = 1;
        if (!per_m) begin
          phase = 2; q_hold = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_q", int'(q), model_q());
      check("model_busy", int'(busy), int'(phase == 1));
      check("model_done", int'(done), int'(phase == 2));
      check("model_tc", int'(tc), int'(tc_exp));
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_start(input int ld, input bit per);
    start = 1'b1; load = W'(ld); periodic = per;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  initial begin
    int tcs;
    int ticks;
    bit seen_zero;
    bit wrapped;

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_q", int'(q), 0);
    check("rst_busy", int'(busy), 0);

    // reset during RUN with Q=5
    en = 1'b0;
    do_start(5, 1'b0);
    check("pre_rst_q", int'(q), 5);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_run_q", int'(q), 0);
    check("rst_run_busy", int'(busy), 0);
    check("rst_run_done", int'(done), 0);
    check("rst_run_tc", int'(tc), 0);

    // one-shot load=3, en held high
    en = 1'b1;
    do_start(3, 1'b0);
    check("os_q3", int'(q), 3);
    tick(1); check("os_q2", int'(q), 2);
    tick(1); check("os_q1", int'(q), 1);
    tick(1); check("os_q0", int'(q), 0);
    check("os_tc_before", int'(tc), 0);
    tick(1);
    check("os_tc", int'(tc), 1);
    check("os_done", int'(done), 1);
    check("os_busy", int'(busy), 0);
    tick(1);
    check("os_tc_off", int'(tc), 0);
    check("os_q_hold", int'(q), 0);

    // periodic load=2 with en every second cycle
    en = 1'b0;
    do_start(2, 1'b1);
    tcs = 0;
    for (int i = 0; i < 12; i++) begin
      en = (i % 2 == 0);
      tick(1);
      if (tc) tcs++;
    end
    check("per_tc_count", tcs, 2);
    check("per_busy", int'(busy), 1);
    check("per_q_reload", int'(q), 2);
    en = 1'b0;
    do_stop();

    // start and stop together at Q=4
    do_start(6, 1'b0);
    en = 1'b1;
    tick(2);
    check("ss_pre_q", int'(q), 4);
    en = 1'b0;
    start = 1'b1; stop = 1'b1; load = W'(9);
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("ss_q", int'(q), 4);
    check("ss_busy", int'(busy), 0);
    check("ss_tc", int'(tc), 0);

    // restart while RUN at Q=1
    do_start(3, 1'b0);
    en = 1'b1;
    tick(2);
    check("rs_pre_q", int'(q), 1);
    do_start(7, 1'b0);
    check("rs_q", int'(q), 7);
    check("rs_busy", int'(busy), 1);
    check("rs_tc", int'(tc), 0);
    en = 1'b0;
    do_stop();

    // load=0 in periodic mode: single tc, then silence
    do_start(0, 1'b1);
    check("z_done", int'(done), 1);
    check("z_tc", int'(tc), 1);
    check("z_q", int'(q), 0);
    en = 1'b1;
    tcs = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (tc) tcs++;
    end
    check("z_no_more_tc", tcs, 0);
    en = 1'b0;
    do_stop();

    // WIDTH=4 instance, load=15 one-shot: 16 ticks to tc, no wrap
    do_start(15, 1'b0);
    check("w4_q", int'(q4), 15);
    en = 1'b1;
    ticks = 0; seen_zero = 0; wrapped = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      ticks++;
      if (seen_zero && q4 == 4'd15) wrapped = 1;
      if (q4 == 4'd0) seen_zero = 1;
      if (tc4) break;
    end
    check("w4_ticks_to_tc", ticks, 16);
    check("w4_tc", int'(tc4), 1);
    tick(3);
    if (seen_zero && q4 == 4'd15) wrapped = 1;
    check("w4_no_wrap", int'(wrapped), 0);
    check("w4_done", int'(done4), 1);
    en = 1'b0;
    do_stop();
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
